pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (2..8).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port stall  input  1  hold PC this cycle.
REQ-006 SHALL have port branch_taken  input  1  PC-relative branch request.
REQ-007 SHALL have port branch_off  input  16  two's-complement branch offset.
REQ-008 SHALL have port jump  input  1  absolute jump request.
REQ-009 SHALL have port call  input  1  absolute jump with push of return address.
REQ-010 SHALL have port target  input  16  absolute address for jump and call.
REQ-011 SHALL have port ret  input  1  pop return address into PC.
REQ-012 SHALL have port halt  input  1  enter HALT state.
REQ-013 SHALL have port resume  input  1  leave HALT state.
REQ-014 SHALL have port err_clr  input  1  clear sticky error flags.
REQ-015 SHALL have port pc  output  16  current program counter (registered).
REQ-016 SHALL have port pc_valid  output  1  pc is a fetchable address (state RUN).
REQ-017 SHALL have port halted  output  1  state is HALT.
REQ-018 SHALL have port ras_depth  output  4  current number of stack entries.
REQ-019 SHALL have port ras_ovf  output  1  sticky: call with full stack.
REQ-020 SHALL have port ras_unf  output  1  sticky: ret with empty stack.

Function
REQ-021 SHALL implement states BOOT, RUN, HALT; BOOT->RUN unconditionally after one cycle; RUN->HALT when halt sampled high and stall low; HALT->RUN when resume sampled high.
REQ-022 SHALL hold pc at RESET_VECTOR during BOOT with pc_valid=0.
REQ-023 SHALL, in RUN, update pc on each rising edge with priority: stall > halt > ret > call > jump > branch_taken > increment.
REQ-024 SHALL hold pc and stack unchanged when stall=1, regardless of the other requests.
REQ-025 SHALL hold pc on the halt edge; in HALT, pc is frozen and pc_valid=0; on the resume edge pc <= pc+1.
REQ-026 SHALL compute increment as pc+1, branch as pc+branch_off, all modulo 2^16 (16'hFFFF+1 = 16'h0000; no saturation, no flag).
REQ-027 SHALL, on jump, load pc <= target.
REQ-028 SHALL, on call with ras_depth<RAS_DEPTH, push pc+1 (mod 2^16) and load pc <= target; ras_depth increments by 1.
REQ-029 SHALL, on call with stack full, not push, set ras_ovf, still load pc <= target.
REQ-030 SHALL, on ret with ras_depth>0, load pc <= top entry and pop; ras_depth decrements by 1.
REQ-031 SHALL, on ret with stack empty, set ras_unf and load pc <= pc+1.
REQ-032 SHALL treat simultaneous call and ret as ret only (priority REQ-023); no push occurs.
REQ-033 SHALL ignore all requests except resume in HALT, and all requests in BOOT.
REQ-034 SHALL clear ras_ovf and ras_unf on the edge err_clr=1; a set event in the same cycle wins (flag stays 1).
REQ-035 SHALL present stack as LIFO; a stack entry is readable by ret in the cycle after its push.

Reset
REQ-036 SHALL, while rst=1 (asynchronously, without waiting for clk), force state=BOOT, pc=RESET_VECTOR, pc_valid=0, halted=0, ras_depth=0, ras_ovf=0, ras_unf=0.
REQ-037 SHALL discard stack contents and any in-flight request when rst asserts mid-operation, including in HALT.
REQ-038 SHALL leave BOOT on the first rising edge after rst deasserts; pc_valid=1 starting on the following edge.

Verification
REQ-039 SHALL cover: reset release, no requests for 4 cycles -> pc sequence 0000 (BOOT, pc_valid=0), 0000, 0001, 0002, 0003 with pc_valid=1.
REQ-040 SHALL cover: pc=0010, branch_off=16'hFFF0 -> pc=0000; pc=FFFF, increment -> pc=0000.
REQ-041 SHALL cover: pc=0020 call target=0100; pc=0100 ret -> pc=0021, ras_depth 1 then 0.
REQ-042 SHALL cover: five calls with RAS_DEPTH=4 -> ras_depth=4, ras_ovf=1; then five rets -> four pops, fifth ret gives pc+1 and ras_unf=1; err_clr -> both 0.
REQ-043 SHALL cover: halt at pc=0040 -> pc stays 0040, halted=1, pc_valid=0 for 3 cycles with jump asserted; resume -> pc=0041.
REQ-044 SHALL cover: stall held 2 cycles with call asserted -> pc and ras_depth unchanged; rst pulse mid-stall -> pc=RESET_VECTOR immediately, ras_depth=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencer with BOOT/RUN/HALT control and a return-address stack.
module pc_sequencer #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000,
   parameter int RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_off,
   input  logic        jump,
   input  logic        call,
   input  logic [15:0] target,
   input  logic        ret,
   input  logic        halt,
   input  logic        resume,
   input  logic        err_clr,
   output logic [15:0] pc,
   output logic        pc_valid,
   output logic        halted,
   output logic [3:0]  ras_depth,
   output logic        ras_ovf,
   output logic        ras_unf
);
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   state_t st, st_n;
   logic [15:0] pc_n;
   logic [15:0] stk [8];
   logic push, pop, ovf_s, unf_s;
   always_comb begin
      st_n = st;
      pc_n = pc;
      push = 1'b0;
      pop = 1'b0;
      ovf_s = 1'b0;
      unf_s = 1'b0;
      if (st == BOOT) st_n = RUN;
      else if (st == HALT) begin
         if (resume) begin
            st_n = RUN;
            pc_n = pc + 16'd1;
         end
      end else if (!stall) begin
         if (halt) st_n = HALT;
         else if (ret) begin
            if (ras_depth != 4'd0) begin
               pop = 1'b1;
               pc_n = stk[ras_depth[2:0] - 3'd1];
            end else begin
               unf_s = 1'b1;
               pc_n = pc + 16'd1;
            end
         end else if (call) begin
            pc_n = target;
            push = ras_depth < 4'(RAS_DEPTH);
            ovf_s = !push;
         end else if (jump) pc_n = target;
         else if (branch_taken) pc_n = pc + branch_off;
         else pc_n = pc + 16'd1;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st <= BOOT;
         pc <= RESET_VECTOR;
         ras_depth <= 4'd0;
         ras_ovf <= 1'b0;
         ras_unf <= 1'b0;
      end else begin
         st <= st_n;
         pc <= pc_n;
         ras_depth <= push ? ras_depth + 4'd1 : pop ? ras_depth - 4'd1 : ras_depth;
         ras_ovf <= ovf_s | (ras_ovf & ~err_clr);
         ras_unf <= unf_s | (ras_unf & ~err_clr);
      end
   end
   // stack storage needs no reset: ras_depth=0 already makes old entries unreachable
   always_ff @(posedge clk)
      if (push) stk[ras_depth[2:0]] <= pc + 16'd1;
   assign pc_valid = st == RUN;
   assign halted = st == HALT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus hand sequences for stack, halt and reset corners.
module tb_pc_sequencer;
   logic clk = 1'b0, rst = 1'b0;
   logic stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
   logic halt = 1'b0, resume = 1'b0, err_clr = 1'b0;
   logic [15:0] branch_off = 16'h0, target = 16'h0, pc;
   logic pc_valid, halted, ras_ovf, ras_unf;
   logic [3:0] ras_depth;
   int tests = 0, fails = 0;

   localparam logic [7:0] NO = 8'h00, ST = 8'h01, BR = 8'h02, JP = 8'h04, CL = 8'h08;
   localparam logic [7:0] RT = 8'h10, HL = 8'h20, RS = 8'h40, EC = 8'h80;
   // fl = {pc_valid, halted, ras_ovf, ras_unf}
   typedef struct {
      logic [7:0]  req;
      logic [15:0] a;
      logic [15:0] epc;
      logic [3:0]  fl;
      logic [3:0]  dep;
   } vec_t;
   vec_t tb [20];

   pc_sequencer #(.RESET_VECTOR(16'h0000), .RAS_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_off(branch_off), .jump(jump), .call(call), .target(target),
      .ret(ret), .halt(halt), .resume(resume), .err_clr(err_clr),
      .pc(pc), .pc_valid(pc_valid), .halted(halted), .ras_depth(ras_depth),
      .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check(input string nm, input logic [15:0] epc, input logic [3:0] fl, input logic [3:0] dep);
      chk({nm, " pc"}, pc, epc);
      chk({nm, " flags"}, {12'h0, pc_valid, halted, ras_ovf, ras_unf}, {12'h0, fl});
      chk({nm, " depth"}, {12'h0, ras_depth}, {12'h0, dep});
   endtask

   task automatic go(input logic [7:0] req, input logic [15:0] a, input logic [15:0] epc,
                     input logic [3:0] fl, input logic [3:0] dep, input string nm);
      {err_clr, resume, halt, ret, call, jump, branch_taken, stall} = req;
      branch_off = a;
      target = a;
      @(posedge clk);
      #1;
      check(nm, epc, fl, dep);
   endtask

   initial begin
      tb[0]  = '{NO,      16'h0000, 16'h0000, 4'b1000, 4'd0};
      tb[1]  = '{NO,      16'h0000, 16'h0001, 4'b1000, 4'd0};
      tb[2]  = '{NO,      16'h0000, 16'h0002, 4'b1000, 4'd0};
      tb[3]  = '{NO,      16'h0000, 16'h0003, 4'b1000, 4'd0};
      tb[4]  = '{JP,      16'h0010, 16'h0010, 4'b1000, 4'd0};
      tb[5]  = '{BR,      16'hFFF0, 16'h0000, 4'b1000, 4'd0};
      tb[6]  = '{JP,      16'hFFFF, 16'hFFFF, 4'b1000, 4'd0};
      tb[7]  = '{NO,      16'h0000, 16'h0000, 4'b1000, 4'd0};
      tb[8]  = '{JP,      16'h0020, 16'h0020, 4'b1000, 4'd0};
      tb[9]  = '{CL,      16'h0100, 16'h0100, 4'b1000, 4'd1};
      tb[10] = '{RT,      16'h0000, 16'h0021, 4'b1000, 4'd0};
      tb[11] = '{CL | RT, 16'h0500, 16'h0022, 4'b1001, 4'd0};
      tb[12] = '{EC,      16'h0000, 16'h0023, 4'b1000, 4'd0};
      tb[13] = '{EC | RT, 16'h0000, 16'h0024, 4'b1001, 4'd0};
      tb[14] = '{EC,      16'h0000, 16'h0025, 4'b1000, 4'd0};
      tb[15] = '{JP | BR, 16'h0200, 16'h0200, 4'b1000, 4'd0};
      tb[16] = '{ST | JP, 16'h0300, 16'h0200, 4'b1000, 4'd0};
      tb[17] = '{BR,      16'h0003, 16'h0203, 4'b1000, 4'd0};
      tb[18] = '{ST | HL, 16'h0000, 16'h0203, 4'b1000, 4'd0};
      tb[19] = '{ST | CL, 16'h0700, 16'h0203, 4'b1000, 4'd0};

      #2 rst = 1'b1;
      #1 check("reset", 16'h0000, 4'b0000, 4'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      check("boot", 16'h0000, 4'b0000, 4'd0);
      for (int i = 0; i < 20; i++) go(tb[i].req, tb[i].a, tb[i].epc, tb[i].fl, tb[i].dep, $sformatf("v%0d", i));

      go(CL, 16'h1000, 16'h1000, 4'b1000, 4'd1, "call1");
      go(CL, 16'h2000, 16'h2000, 4'b1000, 4'd2, "call2");
      go(CL, 16'h3000, 16'h3000, 4'b1000, 4'd3, "call3");
      go(CL, 16'h4000, 16'h4000, 4'b1000, 4'd4, "call4");
      go(CL, 16'h5000, 16'h5000, 4'b1010, 4'd4, "call5");
      go(RT, 16'h0000, 16'h3001, 4'b1010, 4'd3, "ret1");
      go(RT, 16'h0000, 16'h2001, 4'b1010, 4'd2, "ret2");
      go(RT, 16'h0000, 16'h1001, 4'b1010, 4'd1, "ret3");
      go(RT, 16'h0000, 16'h0204, 4'b1010, 4'd0, "ret4");
      go(RT, 16'h0000, 16'h0205, 4'b1011, 4'd0, "ret5");
      go(EC, 16'h0000, 16'h0206, 4'b1000, 4'd0, "errclr");

      go(JP, 16'h0040, 16'h0040, 4'b1000, 4'd0, "jmp40");
      go(HL, 16'h0000, 16'h0040, 4'b0100, 4'd0, "halt");
      for (int i = 0; i < 3; i++) go(JP, 16'h0999, 16'h0040, 4'b0100, 4'd0, $sformatf("hold%0d", i));
      go(RS, 16'h0000, 16'h0041, 4'b1000, 4'd0, "resume");

      go(CL, 16'h0300, 16'h0300, 4'b1000, 4'd1, "call300");
      go(ST | CL, 16'h0400, 16'h0300, 4'b1000, 4'd1, "stall1");
      go(ST | CL, 16'h0400, 16'h0300, 4'b1000, 4'd1, "stall2");
      #3 rst = 1'b1;
      #1 check("rst_stall", 16'h0000, 4'b0000, 4'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      go(NO, 16'h0000, 16'h0000, 4'b1000, 4'd0, "reboot");
      go(NO, 16'h0000, 16'h0001, 4'b1000, 4'd0, "run1");
      go(HL, 16'h0000, 16'h0001, 4'b0100, 4'd0, "halt2");
      #3 rst = 1'b1;
      #1 check("rst_halt", 16'h0000, 4'b0000, 4'd0);
      #10 rst = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
